// File: rtl/decoder38_strobe.sv
// Queued, timed 3-to-8 decoder: FIFO-buffered codes are driven as registered
// one-hot strobes of HOLD_CYCLES cycles, separated by GAP_CYCLES all-zero cycles.
module decoder38_strobe #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1,
  parameter int DEPTH       = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       notEN,
  input  logic [2:0] Input,
  input  logic       InValid,
  output logic       InReady,
  output logic [7:0] Output,
  output logic       Done,
  output logic       Busy
);

  localparam int AW   = $clog2(DEPTH);
  localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [AW:0]   FULL      = (AW + 1)'(DEPTH);
  localparam bit            HAS_GAP   = (GAP_CYCLES > 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  logic [2:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_next;
  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [2:0]    code, code_next;
  logic [7:0]    out_next;
  logic          done_next, busy_next, push, pop, empty;

  function automatic logic [7:0] onehot(input logic [2:0] c);
    onehot = 8'd1 << c;
  endfunction

  assign InReady = (count < FULL);
  assign push    = InValid && InReady;
  assign empty   = (count == '0);

  // Next-state, strobe and pop decisions; a disabled cycle freezes everything but blanks the bus.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    code_next  = code;
    out_next   = Output;
    done_next  = 1'b0;
    pop        = 1'b0;
    if (notEN) begin
      out_next = 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            pop        = 1'b1;
            code_next  = mem[rd_ptr];
            out_next   = onehot(mem[rd_ptr]);
            cnt_next   = HOLD_LOAD;
            state_next = DRIVE;
          end else begin
            out_next = 8'h00;
          end
        end
        DRIVE: begin
          if (cnt != '0) begin
            cnt_next = cnt - CW'(1);
            out_next = onehot(code);
          end else begin
            done_next = 1'b1;
            if (HAS_GAP) begin
              out_next   = 8'h00;
              cnt_next   = GAP_LOAD;
              state_next = GAP;
            end else if (!empty) begin
              pop       = 1'b1;
              code_next = mem[rd_ptr];
              out_next  = onehot(mem[rd_ptr]);
              cnt_next  = HOLD_LOAD;
            end else begin
              out_next   = 8'h00;
              state_next = IDLE;
            end
          end
        end
        GAP: begin
          out_next = 8'h00;
          if (cnt != '0) begin
            cnt_next = cnt - CW'(1);
          end else if (!empty) begin
            pop        = 1'b1;
            code_next  = mem[rd_ptr];
            out_next   = onehot(mem[rd_ptr]);
            cnt_next   = HOLD_LOAD;
            state_next = DRIVE;
          end else begin
            state_next = IDLE;
          end
        end
        default: begin
          out_next   = 8'h00;
          state_next = IDLE;
        end
      endcase
    end
    count_next = count + (AW + 1)'(push) - (AW + 1)'(pop);
    busy_next  = (state_next != IDLE) || (count_next != '0);
  end

  // FSM, counters, FIFO pointers and registered outputs.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state  <= IDLE;
      cnt    <= '0;
      code   <= 3'd0;
      Output <= 8'h00;
      Done   <= 1'b0;
      Busy   <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      code   <= code_next;
      Output <= out_next;
      Done   <= done_next;
      Busy   <= busy_next;
      count  <= count_next;
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge Clock) begin
    if (push && !Reset) begin
      mem[wr_ptr] <= Input;
    end
  end

endmodule

// File: tb/tb_decoder38_strobe.sv
// Bench for decoder38_strobe: directed scenarios plus random traffic against a
// queue-based strobe model; a second instance covers the minimum-timing corner.
module tb_decoder38_strobe;

  localparam int HOLD  = 4;
  localparam int GAP   = 1;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset, nen, valid;
  logic [2:0] data;
  logic       ready, done, busy;
  logic [7:0] out;

  logic       b_reset, b_nen, b_valid;
  logic [2:0] b_data;
  logic       b_ready, b_done, b_busy;
  logic [7:0] b_out;

  always #5 clk = ~clk;

  decoder38_strobe #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .DEPTH(DEPTH)) dut_a (
    .Clock(clk), .Reset(reset), .notEN(nen), .Input(data), .InValid(valid),
    .InReady(ready), .Output(out), .Done(done), .Busy(busy)
  );

  decoder38_strobe #(.HOLD_CYCLES(1), .GAP_CYCLES(0), .DEPTH(4)) dut_b (
    .Clock(clk), .Reset(b_reset), .notEN(b_nen), .Input(b_data), .InValid(b_valid),
    .InReady(b_ready), .Output(b_out), .Done(b_done), .Busy(b_busy)
  );

  int checks = 0;
  int errors = 0;
  bit primed = 1'b0;

  // Reference model: accepted codes, current phase and how much of it has been shown
  int         q[$];
  int         phase = 0;   // 0 idle, 1 strobe, 2 gap
  int         m_code = 0;
  int         shown = 0;
  int         gap_shown = 0;
  logic [7:0] e_out = 8'h00;
  logic       e_done = 1'b0;
  logic       e_busy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_next();
    if (q.size() > 0) begin
      m_code = q.pop_front();
      e_out  = 8'(1 << m_code);
      shown  = 1;
      phase  = 1;
    end else begin
      e_out = 8'h00;
      phase = 0;
    end
  endtask

  task automatic model_edge(input logic r, input logic n, input logic v, input logic [2:0] d);
    bit rdy;
    rdy = (q.size() < DEPTH);
    if (r) begin
      q.delete();
      phase = 0; shown = 0; gap_shown = 0;
      e_out = 8'h00; e_done = 1'b0;
    end else begin
      e_done = 1'b0;
      if (n) begin
        e_out = 8'h00;
      end else if (phase == 0) begin
        start_next();
      end else if (phase == 1) begin
        if (shown < HOLD) begin
          e_out = 8'(1 << m_code);
          shown++;
        end else begin
          e_done = 1'b1;
          if (GAP > 0) begin
            phase = 2; gap_shown = 1; e_out = 8'h00;
          end else begin
            start_next();
          end
        end
      end else begin
        if (gap_shown < GAP) begin
          gap_shown++;
          e_out = 8'h00;
        end else begin
          start_next();
        end
      end
      if (v && rdy) q.push_back(int'(d));
    end
    e_busy = (phase != 0) || (q.size() != 0);
  endtask

  task automatic step();
    if (primed) chk("in_ready", ready, (q.size() < DEPTH));
    @(posedge clk);
    model_edge(reset, nen, valid, data);
    if (reset) primed = 1'b1;
    @(negedge clk);
    if (primed) begin
      chk("output", out, e_out);
      chk("done", done, e_done);
      chk("busy", busy, e_busy);
      chk("onehot", ($countones(out) <= 1), 1'b1);
    end
  endtask

  task automatic push_wait(input logic [2:0] c);
    int w;
    valid = 1'b1;
    data  = c;
    w = 0;
    while (!ready && w < 50) begin
      step();
      w++;
    end
    chk("push_bound", (w < 50), 1'b1);
    step();
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (busy && w < 200) begin
      step();
      w++;
    end
    chk("drain_bound", (w < 200), 1'b1);
  endtask

  initial begin
    reset = 1'b1; nen = 1'b0; valid = 1'b0; data = 3'd0;
    b_reset = 1'b1; b_nen = 1'b0; b_valid = 1'b0; b_data = 3'd0;

    // Reset held two cycles
    step(); step();
    reset = 1'b0; b_reset = 1'b0;
    chk("rst_out", out, 8'h00);
    chk("rst_done", done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", ready, 1'b1);
    step();

    // Single code 5
    push_wait(3'd5);
    valid = 1'b0;
    step();
    chk("single_out", out, 8'h20);
    repeat (3) step();
    chk("single_last", out, 8'h20);
    step();
    chk("single_done", done, 1'b1);
    chk("single_gap", out, 8'h00);
    drain();
    chk("single_idle", busy, 1'b0);

    // Back-pressure: five codes with InValid held
    push_wait(3'd0); push_wait(3'd7); push_wait(3'd2); push_wait(3'd3); push_wait(3'd1);
    valid = 1'b0;
    drain();

    // Pause mid-strobe
    push_wait(3'd3);
    valid = 1'b0;
    step(); step();
    chk("pause_pre", out, 8'h08);
    nen = 1'b1;
    repeat (3) begin
      step();
      chk("pause_off", out, 8'h00);
    end
    nen = 1'b0;
    step(); step();
    chk("pause_resume", out, 8'h08);
    step();
    chk("pause_done", done, 1'b1);
    drain();

    // Reset mid-strobe with codes queued
    push_wait(3'd1); push_wait(3'd2); push_wait(3'd4);
    valid = 1'b0;
    step();
    reset = 1'b1;
    step();
    chk("mid_rst_out", out, 8'h00);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    reset = 1'b0;
    push_wait(3'd6);
    valid = 1'b0;
    step();
    chk("post_rst_out", out, 8'h40);
    drain();

    // Random traffic with occasional pauses and resets
    repeat (600) begin
      valid = 1'($urandom_range(0, 1));
      data  = 3'($urandom_range(0, 7));
      nen   = ($urandom_range(0, 9) == 0);
      reset = ($urandom_range(0, 99) == 0);
      step();
    end
    valid = 1'b0; nen = 1'b0; reset = 1'b0;
    drain();

    // Minimum timing instance: HOLD 1, GAP 0
    b_valid = 1'b1; b_data = 3'd1;
    step();
    b_data = 3'd6;
    step();
    b_valid = 1'b0;
    chk("min_out1", b_out, 8'h02);
    chk("min_done1", b_done, 1'b0);
    step();
    chk("min_out2", b_out, 8'h40);
    chk("min_done2", b_done, 1'b1);
    step();
    chk("min_out3", b_out, 8'h00);
    chk("min_done3", b_done, 1'b1);
    step();
    chk("min_done4", b_done, 1'b0);
    chk("min_busy", b_busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
